// File: rtl/iq_if_sample_player.sv
// I/Q IF replay source: plays a stored sample buffer paced by a programmable EOC strobe, with a read-enable window.
// Latency: first emit `period` clocks after start; outputs are combinational from state; there is no backpressure (free-running pacing).
module iq_if_sample_player #(
  parameter int W     = 4,
  parameter int DEPTH = 1024,
  parameter int PW    = 8,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_I,
  input  logic [W-1:0]  i_wr_Q,
  input  logic [AW:0]   i_len,
  input  logic [PW-1:0] i_period,
  input  logic          i_loop,
  input  logic [AW-1:0] i_win_lo,
  input  logic [AW-1:0] i_win_hi,
  input  logic          i_start,
  input  logic          i_stop,
  output logic [W-1:0]  o_I_if,
  output logic [W-1:0]  o_Q_if,
  output logic          o_adc_eoc,
  output logic          o_read_en,
  output logic [AW-1:0] o_idx,
  output logic          o_busy,
  output logic          o_done
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  mem_i [DEPTH];
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  rd_i_q, rd_q_q;
  logic [AW:0]   len_q;
  logic [PW-1:0] period_q, tick_q;
  logic          loop_q;
  logic [AW-1:0] win_lo_q, win_hi_q, idx_q;
  logic          do_start, emit, last, rd_issue;

  assign last     = ({1'b0, idx_q} == len_q - (AW+1)'(1));
  assign rd_issue = (state_q == S_PLAY) && (tick_q == period_q - PW'(2));

  always_comb begin
    state_d  = state_q;
    do_start = 1'b0;
    emit     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start && !i_stop) begin
          state_d  = S_PLAY;
          do_start = 1'b1;
        end
      end
      S_PLAY: begin
        // An emit in the stop/restart cycle still reaches the outputs.
        emit = (tick_q == period_q - PW'(1));
        if (i_stop) begin
          state_d = S_IDLE;
        end else if (i_start) begin
          do_start = 1'b1;
        end else if (emit && last && !loop_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (i_start) begin
          state_d  = S_PLAY;
          do_start = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tick_q   <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      period_q <= '0;
      loop_q   <= 1'b0;
      win_lo_q <= '0;
      win_hi_q <= '0;
      rd_i_q   <= '0;
      rd_q_q   <= '0;
    end else begin
      if (do_start) begin
        len_q    <= i_len;
        period_q <= (i_period < PW'(2)) ? PW'(2) : i_period;
        loop_q   <= i_loop;
        win_lo_q <= i_win_lo;
        win_hi_q <= i_win_hi;
        tick_q   <= '0;
        idx_q    <= '0;
      end else if (state_q == S_PLAY) begin
        tick_q <= emit ? '0 : tick_q + PW'(1);
        if (emit) idx_q <= last ? '0 : idx_q + AW'(1);
      end
      // Read one cycle ahead so the sample is registered on the emit cycle.
      if (rd_issue) begin
        rd_i_q <= mem_i[idx_q];
        rd_q_q <= mem_q[idx_q];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en && state_q != S_PLAY) begin
      mem_i[i_wr_addr] <= i_wr_I;
      mem_q[i_wr_addr] <= i_wr_Q;
    end
  end

  assign o_adc_eoc = emit;
  assign o_I_if    = emit ? rd_i_q : '0;
  assign o_Q_if    = emit ? rd_q_q : '0;
  assign o_idx     = emit ? idx_q : '0;
  assign o_read_en = emit && (win_lo_q < idx_q) && (idx_q < win_hi_q);
  assign o_busy    = (state_q == S_PLAY);
  assign o_done    = (state_q == S_DONE);

endmodule

// File: tb/tb_iq_if_sample_player.sv
// Bench for iq_if_sample_player: per-cycle comparison against an arithmetic playback model.
module tb_iq_if_sample_player;

  localparam int W = 4, DEPTH = 16, PW = 8, AW = 4;

  logic          clk = 1'b0;
  logic          i_rst, i_wr_en, i_loop, i_start, i_stop;
  logic [AW-1:0] i_wr_addr, i_win_lo, i_win_hi;
  logic [W-1:0]  i_wr_I, i_wr_Q;
  logic [AW:0]   i_len;
  logic [PW-1:0] i_period;
  logic [W-1:0]  o_I_if, o_Q_if;
  logic          o_adc_eoc, o_read_en, o_busy, o_done;
  logic [AW-1:0] o_idx;

  iq_if_sample_player #(.W(W), .DEPTH(DEPTH), .PW(PW)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_I(i_wr_I), .i_wr_Q(i_wr_Q), .i_len(i_len), .i_period(i_period),
    .i_loop(i_loop), .i_win_lo(i_win_lo), .i_win_hi(i_win_hi),
    .i_start(i_start), .i_stop(i_stop), .o_I_if(o_I_if), .o_Q_if(o_Q_if),
    .o_adc_eoc(o_adc_eoc), .o_read_en(o_read_en), .o_idx(o_idx),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [3:0] si;
    logic [3:0] sq;
    logic       eoc;
    logic       ren;
    logic [3:0] idx;
    logic       busy;
    logic       done;
  } obs_t;

  int         n_cmp = 0;
  int         n_mis = 0;
  logic [3:0] mb_i [DEPTH];
  logic [3:0] mb_q [DEPTH];
  int         c_len, c_per, c_lo, c_hi;
  bit         c_loop;
  obs_t       e, a;

  // Expected outputs n clocks after the start pulse was sampled.
  function automatic obs_t model(int n);
    obs_t r;
    int pe, j;
    r  = '0;
    pe = (c_per < 2) ? 2 : c_per;
    if (!c_loop && n > c_len * pe) begin
      r.done = 1'b1;
      return r;
    end
    r.busy = 1'b1;
    if (n % pe == 0) begin
      j     = (n / pe - 1) % c_len;
      r.eoc = 1'b1;
      r.si  = mb_i[j];
      r.sq  = mb_q[j];
      r.idx = 4'(j);
      r.ren = (c_lo < j) && (j < c_hi);
    end
    return r;
  endfunction

  function automatic obs_t sample();
    return obs_t'({o_I_if, o_Q_if, o_adc_eoc, o_read_en, o_idx, o_busy, o_done});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_play(input int len, input int per, input bit lp, input int lo, input int hi);
    c_len = len; c_per = per; c_loop = lp; c_lo = lo; c_hi = hi;
    i_len = 5'(len); i_period = 8'(per); i_loop = lp;
    i_win_lo = 4'(lo); i_win_hi = 4'(hi);
    i_start = 1'b1;
  endtask

  task automatic load_buffer();
    for (int k = 0; k < DEPTH; k++) begin
      mb_i[k] = 4'(k);
      mb_q[k] = 4'($urandom_range(0, 15));
      i_wr_en = 1'b1; i_wr_addr = 4'(k); i_wr_I = mb_i[k]; i_wr_Q = mb_q[k];
      step();
    end
    i_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) step();
    a = sample();
    n_cmp++;
    if (a !== obs_t'(0)) begin n_mis++; $display("FAIL reset_hold act=%h exp=%h", a, obs_t'(0)); end
    i_rst = 1'b0;
    step();
    a = sample();
    n_cmp++;
    if (a !== obs_t'(0)) begin n_mis++; $display("FAIL reset_idle act=%h exp=%h", a, obs_t'(0)); end
  endtask

  task automatic test_oneshot();
    start_play(16, 5, 1'b0, 0, 0);
    for (int n = 1; n <= 16 * 5 + 5; n++) begin
      step();
      i_start = 1'b0;
      i_stop  = (n == 16 * 5 + 2);
      e = model(n); a = sample();
      n_cmp++;
      if (a !== e) begin n_mis++; $display("FAIL oneshot n=%0d act=%h exp=%h", n, a, e); end
    end
    i_stop = 1'b0;
  endtask

  task automatic test_loop_window();
    start_play(10, 5, 1'b1, 3, 7);
    for (int n = 1; n <= 10 * 5 * 3 + 2; n++) begin
      step();
      i_start = 1'b0;
      i_wr_en = (n == 7);
      i_wr_addr = 4'd8; i_wr_I = ~mb_i[8]; i_wr_Q = ~mb_q[8];
      e = model(n); a = sample();
      n_cmp++;
      if (a !== e) begin n_mis++; $display("FAIL loop_window n=%0d act=%h exp=%h", n, a, e); end
    end
    i_wr_en = 1'b0;
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    a = sample();
    n_cmp++;
    if (a !== obs_t'(0)) begin n_mis++; $display("FAIL loop_stop act=%h exp=%h", a, obs_t'(0)); end
  endtask

  task automatic test_period_clamp();
    int pers [2];
    pers[0] = 2; pers[1] = 0;
    for (int p = 0; p < 2; p++) begin
      start_play(4, pers[p], 1'b0, 2, 3);
      for (int n = 1; n <= 4 * 2 + 3; n++) begin
        step();
        i_start = 1'b0;
        e = model(n); a = sample();
        n_cmp++;
        if (a !== e) begin n_mis++; $display("FAIL clamp per=%0d n=%0d act=%h exp=%h", pers[p], n, a, e); end
      end
    end
  endtask

  task automatic test_stop_then_write_start();
    start_play(16, 3, 1'b0, 0, 15);
    for (int n = 1; n <= 16; n++) begin
      step();
      i_start = 1'b0;
      e = (n > 11) ? obs_t'(0) : model(n);
      a = sample();
      n_cmp++;
      if (a !== e) begin n_mis++; $display("FAIL stop n=%0d act=%h exp=%h", n, a, e); end
      i_stop = (n == 11);
    end
    i_stop = 1'b0;
    mb_i[0] = 4'hF; mb_q[0] = 4'hF;
    i_wr_en = 1'b1; i_wr_addr = 4'd0; i_wr_I = 4'hF; i_wr_Q = 4'hF;
    start_play(4, 3, 1'b0, 0, 4);
    for (int n = 1; n <= 4 * 3 + 2; n++) begin
      step();
      i_start = 1'b0; i_wr_en = 1'b0;
      e = model(n); a = sample();
      n_cmp++;
      if (a !== e) begin n_mis++; $display("FAIL write_start n=%0d act=%h exp=%h", n, a, e); end
    end
  endtask

  task automatic test_back_to_back();
    start_play(16, 4, 1'b1, 1, 9);
    for (int n = 1; n <= 12; n++) begin
      step();
      i_start = 1'b0;
      e = model(n); a = sample();
      n_cmp++;
      if (a !== e) begin n_mis++; $display("FAIL restart_a n=%0d act=%h exp=%h", n, a, e); end
    end
    start_play(5, 3, 1'b0, 1, 4);
    for (int n = 1; n <= 5 * 3 + 3; n++) begin
      step();
      i_start = 1'b0;
      e = model(n); a = sample();
      n_cmp++;
      if (a !== e) begin n_mis++; $display("FAIL restart_b n=%0d act=%h exp=%h", n, a, e); end
    end
  endtask

  task automatic test_reset_mid();
    start_play(8, 4, 1'b1, 0, 8);
    for (int n = 1; n <= 13; n++) begin
      step();
      i_start = 1'b0;
      e = model(n); a = sample();
      n_cmp++;
      if (a !== e) begin n_mis++; $display("FAIL rst_mid_pre n=%0d act=%h exp=%h", n, a, e); end
    end
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      a = sample();
      n_cmp++;
      if (a !== obs_t'(0)) begin n_mis++; $display("FAIL rst_mid_idle c=%0d act=%h exp=%h", n, a, obs_t'(0)); end
      step();
    end
    start_play(8, 4, 1'b1, 0, 8);
    for (int n = 1; n <= 8 * 4 + 6; n++) begin
      step();
      i_start = 1'b0;
      e = model(n); a = sample();
      n_cmp++;
      if (a !== e) begin n_mis++; $display("FAIL rst_mid_replay n=%0d act=%h exp=%h", n, a, e); end
    end
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
  endtask

  task automatic test_random();
    int len, per, pe, lo, hi, nmax;
    bit lp;
    for (int it = 0; it < 8; it++) begin
      len = $urandom_range(1, 16);
      per = $urandom_range(0, 6);
      lp  = 1'($urandom_range(0, 1));
      lo  = $urandom_range(0, 15);
      hi  = $urandom_range(0, 15);
      pe  = (per < 2) ? 2 : per;
      nmax = lp ? 2 * len * pe + 3 : len * pe + 2;
      start_play(len, per, lp, lo, hi);
      for (int n = 1; n <= nmax; n++) begin
        step();
        i_start = 1'b0;
        e = model(n); a = sample();
        n_cmp++;
        if (a !== e) begin n_mis++; $display("FAIL random it=%0d n=%0d act=%h exp=%h", it, n, a, e); end
      end
      i_stop = 1'b1;
      step();
      i_stop = 1'b0;
      e = '0;
      e.done = !lp;
      a = sample();
      n_cmp++;
      if (a !== e) begin n_mis++; $display("FAIL random_end it=%0d act=%h exp=%h", it, a, e); end
    end
  endtask

  initial begin
    i_rst = 1'b1; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_I = '0; i_wr_Q = '0;
    i_len = '0; i_period = '0; i_loop = 1'b0; i_win_lo = '0; i_win_hi = '0;
    i_start = 1'b0; i_stop = 1'b0;
    step();
    test_reset();
    load_buffer();
    test_oneshot();
    test_loop_window();
    test_period_clamp();
    test_stop_then_write_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/iq_if_sample_player.md
Name: iq_if_sample_player

Overview:
- Synthesizable replay source for the demod/CORDIC/CDR chain. It stores a buffer of I/Q IF samples and streams them out paced by a programmable ADC end-of-conversion (EOC) strobe.
- It also generates a read-enable window for downstream FIFO readout.
- It is the parametrised, in-fabric successor to the file-driven stimulus loop. Width, depth and pacing are configurable, and it adds one-shot/loop modes, a load port, start/stop control and a done flag.

Parameters:
- W, 4, I and Q sample width in bits (two's-complement pass-through, no arithmetic).
- DEPTH, 1024, sample buffer entries; AW = clog2(DEPTH).
- PW, 8, width of the EOC period field.

Ports:
- i_clk  in  1  system clock (50 MHz nominal).
- i_rst  in  1  synchronous reset, active-high.
- i_wr_en  in  1  buffer write strobe; accepted only in IDLE or DONE.
- i_wr_addr  in  AW  buffer write address.
- i_wr_I  in  W  I sample to store.
- i_wr_Q  in  W  Q sample to store.
- i_len  in  AW+1  number of samples to play, 1..DEPTH; sampled at start.
- i_period  in  PW  EOC period in clocks, 2..2^PW-1; sampled at start.
- i_loop  in  1  1 = wrap and replay forever; 0 = one-shot; sampled at start.
- i_win_lo  in  AW  read-enable window lower bound (exclusive); sampled at start.
- i_win_hi  in  AW  read-enable window upper bound (exclusive); sampled at start.
- i_start  in  1  one-cycle pulse; begins playback from index 0.
- i_stop  in  1  one-cycle pulse; aborts playback.
- o_I_if  out  W  I sample; valid on o_eoc cycles, 0 otherwise.
- o_Q_if  out  W  Q sample; valid on o_eoc cycles, 0 otherwise.
- o_adc_eoc  out  1  one-cycle strobe per emitted sample.
- o_read_en  out  1  one-cycle strobe coincident with o_adc_eoc when win_lo < idx < win_hi.
- o_idx  out  AW  buffer index of the sample currently on the bus.
- o_busy  out  1  high in PLAY.
- o_done  out  1  high in DONE (one-shot completed); cleared by start or reset.

Behaviour:
Reset:
- All outputs are 0; the FSM goes to IDLE; tick counter and index are 0.
- Buffer contents are not reset.

FSM has three states: IDLE, PLAY, DONE.
- IDLE -> PLAY on i_start. Latch len, period, loop, win_lo and win_hi; set idx = 0 and tick = 0.
- PLAY, per clock:
  - If tick == period-1: tick <= 0 and emit. Otherwise tick <= tick+1.
  - First emit occurs `period` clocks after the start pulse. Emits then repeat exactly every `period` clocks.
- Emit cycle:
  - o_adc_eoc = 1; o_I_if/o_Q_if = buf[idx]; o_idx = idx.
  - o_read_en = 1 if win_lo < idx < win_hi.
  - Next index: idx <= idx+1 if idx < len-1.
- End of buffer (idx == len-1):
  - loop = 1: idx <= 0. Every entry 0..len-1 plays once per pass; no skipped or duplicated entry at the wrap.
  - loop = 0: go to DONE after this emit.
- Buffer is synchronous-read:
  - Read address idx is issued when tick == period-2, so data is registered on the emit cycle.
  - i_period < 2 is clamped to 2.
- i_stop in PLAY: go to IDLE next clock. Any emit in that same cycle still completes. No done flag.
- i_start while in PLAY restarts from idx 0 with freshly sampled configuration.
- i_start and i_stop in the same cycle: stop wins.
- DONE -> PLAY on i_start. DONE ignores i_stop. o_done stays high until start or reset.
- Writes (i_wr_en) in PLAY are dropped.
- A write and a start in the same cycle: the write is accepted, then playback begins.
- Window is empty if win_hi <= win_lo+1, so o_read_en never asserts.
- Reset mid-playback: the next clock returns to IDLE with all outputs 0.

Test Plan:
- Load buf[k] = k mod 16 (W=4, DEPTH=16); len=16, period=5, loop=0; start -> 16 eoc pulses spaced 5 clocks, first 5 clocks after start, data 0..15; o_done=1 one clock after the 16th eoc; o_I_if=0 between pulses.
- Same load, loop=1, len=10 -> data sequence 0..9,0..9,...; idx wraps 9->0 with no gap or repeat; o_done stays 0.
- win_lo=3, win_hi=7 -> o_read_en high only on eoc cycles with idx 4, 5, 6 on every pass.
- period=2, len=4 -> eoc every 2nd clock, data 0,1,2,3; period=0 behaves identically (clamp).
- Stop asserted 2 clocks after the 3rd eoc -> no further eoc; busy=0, done=0; write buf[0]=0xF then start -> first emitted sample is 0xF.
- Assert i_rst for 1 cycle mid-PLAY -> all outputs 0 next clock; FSM in IDLE; buffer contents preserved on the next start.
